dco_freq_meter: RTL and testbench



---
 rtl/dco_freq_meter.sv | 129 ++++++++++++
 tb/tb_dco_freq_meter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dco_freq_meter.sv
// Frequency counter for the DCO output: counts synchronized rising edges of
// dco_in over a gate window of gate_len system clocks, one-shot or continuous.
module dco_freq_meter #(
    parameter int GATE_W      = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dco_in,
    input  logic              start,
    input  logic              continuous,
    input  logic [GATE_W-1:0] gate_len,
    output logic [CNT_W-1:0]  count,
    output logic              count_valid,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   p_q;
    logic                   s;
    logic                   rise;
    logic [GATE_W-1:0]      glen_load;
    logic [GATE_W-1:0]      gcnt_q, gcnt_d;
    logic [CNT_W-1:0]       edge_q, edge_d;
    logic                   sat_q, sat_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~p_q;

    // A zero-length gate would never reach the terminal count, so it runs as one cycle.
    assign glen_load = (gate_len == '0) ? GATE_ONE : gate_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            p_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], dco_in};
            p_q    <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gcnt_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        edge_d  = edge_q;
        sat_d   = sat_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MEASURE;
                    gcnt_d  = glen_load;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (&edge_q) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_d = edge_q + CNT_ONE;
                    end
                end
                gcnt_d = gcnt_q - GATE_ONE;
                // Result registers take the next-state values so the rise in the
                // last gate cycle is included and count is valid during DONE.
                if (gcnt_q == GATE_ONE) begin
                    state_d = DONE;
                    count_d = edge_d;
                    ovf_d   = sat_d;
                end
            end
            DONE: begin
                if (continuous) begin
                    state_d = MEASURE;
                    gcnt_d  = glen_load;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign count       = count_q;
    assign overflow    = ovf_q;
    assign count_valid = (state_q == DONE);
    assign busy        = (state_q == MEASURE);

endmodule

// File: tb/tb_dco_freq_meter.sv
// Directed bench for dco_freq_meter: table of one-shot measurements plus
// continuous-mode, busy-start, reset and 4-bit saturation sequences.
module tb_dco_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        dco;
    logic        start;
    logic        start2;
    logic        continuous;
    logic [15:0] gate_len;
    logic [15:0] count;
    logic        count_valid, busy, overflow;
    logic [3:0]  count2;
    logic        cv2, busy2, ovf2;

    int total = 0;
    int bad   = 0;
    int per   = 0;
    int ph    = 0;

    always #5 clk = ~clk;

    dco_freq_meter #(.GATE_W(16), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .dco_in(dco), .start(start), .continuous(continuous),
        .gate_len(gate_len), .count(count), .count_valid(count_valid),
        .busy(busy), .overflow(overflow)
    );

    dco_freq_meter #(.GATE_W(16), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .dco_in(dco), .start(start2), .continuous(1'b0),
        .gate_len(gate_len), .count(count2), .count_valid(cv2),
        .busy(busy2), .overflow(ovf2)
    );

    // per: 0 = static low, 1 = static high, N>=2 = square wave of period N clocks
    initial begin
        dco = 1'b0;
        forever begin
            @(negedge clk);
            ph++;
            if (per == 0)      dco = 1'b0;
            else if (per == 1) dco = 1'b1;
            else               dco = ((ph % per) < (per / 2));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic set_dco(input int p);
        per = p;
        cycles(10);
    endtask

    // Called at a negedge; returns latency in cycles to count_valid (-1 if none).
    task automatic measure(input int gl, input int limit, output int lat, output int bcy);
        gate_len = gl[15:0];
        start    = 1'b1;
        lat      = -1;
        bcy      = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bcy++;
            if (count_valid) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        int   gl;
        int   period;
        int   exp_cnt;
        int   exp_lat;
        int   exp_busy;
        logic exp_ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, bcy, nval, first, vcount;
        int vt[$];

        vecs[0] = '{gl: 50, period: 0, exp_cnt: 0,  exp_lat: 51, exp_busy: 50, exp_ovf: 1'b0};
        vecs[1] = '{gl: 50, period: 1, exp_cnt: 0,  exp_lat: 51, exp_busy: 50, exp_ovf: 1'b0};
        vecs[2] = '{gl: 64, period: 8, exp_cnt: 8,  exp_lat: 65, exp_busy: 64, exp_ovf: 1'b0};
        vecs[3] = '{gl: 40, period: 2, exp_cnt: 20, exp_lat: 41, exp_busy: 40, exp_ovf: 1'b0};
        vecs[4] = '{gl: 30, period: 6, exp_cnt: 5,  exp_lat: 31, exp_busy: 30, exp_ovf: 1'b0};
        vecs[5] = '{gl: 0,  period: 0, exp_cnt: 0,  exp_lat: 2,  exp_busy: 1,  exp_ovf: 1'b0};

        rst = 1'b1; start = 1'b0; start2 = 1'b0; continuous = 1'b0; gate_len = '0;
        cycles(3);
        chk("reset_count", count, 0);
        chk("reset_valid", count_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_busy4", busy2, 0);
        rst = 1'b0;
        cycles(2);

        foreach (vecs[i]) begin
            set_dco(vecs[i].period);
            measure(vecs[i].gl, 200, lat, bcy);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_count", i), count, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
            chk($sformatf("vec%0d_busy_cycles", i), bcy, vecs[i].exp_busy);
            @(negedge clk);
            chk($sformatf("vec%0d_valid_one_cycle", i), count_valid, 0);
            chk($sformatf("vec%0d_count_held", i), count, vecs[i].exp_cnt);
        end

        // continuous mode: results every 17 cycles, drop continuous in the 4th window
        set_dco(4);
        continuous = 1'b1;
        gate_len   = 16'd16;
        start      = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 60) continuous = 1'b0;
            if (count_valid) begin
                vt.push_back(k);
                chk($sformatf("cont_count_k%0d", k), count, 4);
                chk($sformatf("cont_busy_at_done_k%0d", k), busy, 0);
            end
        end
        chk("cont_num_results", vt.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < vt.size()) chk($sformatf("cont_valid_time%0d", i), vt[i], 17 * (i + 1));
        end
        chk("cont_final_busy", busy, 0);

        // start while busy is ignored
        set_dco(4);
        gate_len = 16'd20;
        start    = 1'b1;
        nval = 0; first = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = (k == 5);
            if (count_valid) begin
                nval++;
                if (first < 0) first = k;
                vcount = count;
            end
        end
        chk("busystart_results", nval, 1);
        chk("busystart_latency", first, 21);
        chk("busystart_count", vcount, 5);

        // reset in the middle of a 100-cycle window
        gate_len = 16'd100;
        start    = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_count", count, 0);
        chk("midrst_valid", count_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ovf", overflow, 0);
        nval = 0;
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            if (count_valid || busy) nval++;
        end
        chk("midrst_no_activity", nval, 0);
        measure(16, 100, lat, bcy);
        chk("postrst_latency", lat, 17);
        chk("postrst_count", count, 4);

        // 4-bit counter saturates instead of wrapping
        set_dco(2);
        gate_len = 16'd40;
        start2   = 1'b1;
        lat      = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (cv2) begin
                lat = k;
                break;
            end
        end
        chk("sat_latency", lat, 41);
        chk("sat_count", count2, 15);
        chk("sat_ovf", ovf2, 1);

        // a following in-range window clears overflow
        set_dco(4);
        gate_len = 16'd16;
        start2   = 1'b1;
        lat      = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (cv2) begin
                lat = k;
                break;
            end
        end
        chk("unsat_latency", lat, 17);
        chk("unsat_count", count2, 4);
        chk("unsat_ovf", ovf2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
